fetch_seq: RTL
==============

Name: fetch_seq

Overview:
Multi-cycle fetch/execute sequencer for the RISC-V core. It owns the architectural PC register, fetches instructions from instruction memory over a request/grant/response handshake, and presents each instruction to the datapath for one or more execute cycles. On retire it loads the next PC produced by pccalc (sequential, branch, JAL or JALR target). It stops the core on halt or on a misaligned next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; equals pc
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  instruction data valid this cycle
imem_rdata  in  32  instruction word
instr  out  32  latched instruction for datapath decode
instr_valid  out  1  high throughout EXEC
retire  out  1  instruction completes this cycle; qualifies regfile/dmem writes
pc  out  32  PC of current instruction; feeds pccalc
next_pc  in  32  next PC from pccalc, combinational from pc/instr/ALU flags
stall  in  1  datapath not done (e.g. data memory busy); hold EXEC
halt  in  1  current instruction is ECALL/EBREAK
halted  out  1  core stopped; sticky until rst
misaligned  out  1  stop cause: next_pc[1:0] != 0; sticky until rst
retire_count  out  32  retired-instruction counter

Behaviour:
- Reset (rst high at edge): state=IDLE, pc=RESET_PC, instr=0, retire_count=0, halted=0, misaligned=0. All outputs are driven from these values while rst is high: imem_req=0, instr_valid=0, retire=0. Reset in any state, including mid-handshake, aborts the operation.
- States: IDLE, FETCH, WAIT, EXEC, HALT.
- IDLE: imem_req=0. Always goes to FETCH next cycle. Exactly 1 cycle after rst deassert.
- FETCH: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT; otherwise stay, with req and addr held stable.
- WAIT: imem_req=0. On imem_rvalid, instr<=imem_rdata and go to EXEC. Otherwise stay; there is no timeout.
- imem_rvalid is ignored in every state except WAIT, including a response in the same cycle as gnt. The earliest legal response is the cycle after gnt. Responses arriving after a reset abort are dropped.
- EXEC: instr_valid=1, and instr and pc are held stable.
  - stall=1: stay; retire=0.
  - stall=0: retire=1 for exactly this cycle and retire_count increments (wraps 0xFFFF_FFFF -> 0). Priority order:
    1. halt=1: go to HALT, halted<=1, pc unchanged.
    2. next_pc[1:0]!=0: go to HALT, halted<=1, misaligned<=1, pc unchanged. The faulting instruction still retires and is counted.
    3. Otherwise: pc<=next_pc, go to FETCH.
  - halt and stall are sampled only in EXEC; they are ignored elsewhere.
- HALT: all outputs idle (imem_req=0, instr_valid=0, retire=0). Remains until rst.
- Best-case throughput: FETCH(gnt) -> WAIT(rvalid) -> EXEC = 3 cycles per instruction. First request is 1 cycle after reset release.
- pc changes only on a non-halting retire or on reset.

Test Plan:
1. RESET_PC=0, zero-wait memory (gnt in FETCH, rvalid next cycle), next_pc=pc+4 -> imem_req high on cycle 1 after rst release; addrs 0x0, 0x4, 0x8 on successive 3-cycle slots; retire_count=3 after the third EXEC.
2. Branch: at pc=0x8 drive next_pc=0xAC in EXEC -> next FETCH has imem_addr=0xAC; pc=0xAC; one retire pulse.
3. Handshake hold: gnt withheld 3 cycles, then rvalid 2 cycles after gnt; also pulse rvalid during FETCH with 0xDEADBEEF -> req/addr stable during the 3 cycles; the stray 0xDEADBEEF is not latched; instr equals the WAIT-phase rdata.
4. Stall: stall=1 for 4 EXEC cycles, then 0 -> instr_valid high 5 cycles; retire high only in the last; retire_count +1; pc updates once.
5. Halt vs misalign: halt=1 with stall=1 for 2 cycles, then stall=0 -> HALT entered only after stall drops; halted=1, misaligned=0, no further imem_req. Separate run with next_pc=0x102 -> halted=1, misaligned=1, pc holds old value, retire_count incremented.
6. Reset mid-WAIT: assert rst 1 cycle while in WAIT, then deliver rvalid during IDLE/FETCH -> response dropped; pc=RESET_PC; fresh fetch at RESET_PC; retire_count=0; both flags cleared.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: multi-cycle fetch/execute sequencer for the RISC-V core.
// It owns the architectural PC and fetches each instruction over a
// request/grant/response handshake. It holds the instruction in EXEC until
// the datapath finishes, then either loads next_pc or stops the core on a
// halt or a misaligned target.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   imem_req, imem_addr      fetch request and address (address is always pc)
//   imem_gnt                 memory accepted the request
//   imem_rvalid, imem_rdata  instruction response, honoured only in WAIT
//   instr, instr_valid       latched instruction; valid throughout EXEC
//   retire                   single-cycle pulse when an instruction completes
//   pc, next_pc              current PC out; next PC in, from pccalc
//   stall, halt              datapath busy; ECALL/EBREAK (sampled in EXEC only)
//   halted, misaligned       sticky stop flags
//   retire_count             number of retired instructions (wraps)
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        retire,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        halt,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        halted_q, halted_d;
  logic        misaligned_q, misaligned_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        retire_w;

  // Next-state logic. The response is accepted only in WAIT, so any stray
  // rvalid (during FETCH, in the grant cycle, or after a reset abort) is
  // dropped here. A retiring instruction is always counted, even one that
  // faults on its target; pc moves only when the core keeps running.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    count_d      = count_q;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    retire_w     = 1'b0;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem_gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          retire_w = 1'b1;
          count_d  = count_q + 32'd1;
          if (halt) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else if (next_pc[1:0] != 2'b00) begin
            halted_d     = 1'b1;
            misaligned_d = 1'b1;
            state_d      = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Request and valid are registered, derived from the state being entered.
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_EXEC);
  end

  // State and architectural registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      count_q      <= 32'd0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      count_q      <= count_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
    end
  end

  // Handshake outputs are forced idle while rst is asserted, so a reset
  // that is held before its first edge already quiets the bus.
  always_comb begin
    imem_req     = req_q & ~rst;
    instr_valid  = valid_q & ~rst;
    retire       = retire_w & ~rst;
    imem_addr    = pc_q;
    pc           = pc_q;
    instr        = instr_q;
    halted       = halted_q;
    misaligned   = misaligned_q;
    retire_count = count_q;
  end

endmodule
